// File: rtl/piso_bit_serializer.sv
// Parallel-in/serial-out stage: accepts a WIDTH-bit word on a valid/ready load and shifts it
// out one bit per clock, first bit the cycle after accept; reload on the last bit avoids bubbles.
module piso_bit_serializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             frame_done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    logic             state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             last_bit;
    logic             accept;
    logic [WIDTH-1:0] shifted;

    assign last_bit   = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);
    assign load_ready = (state_q == ST_IDLE) || last_bit;
    assign accept     = load_valid && load_ready;

    assign out_valid  = (state_q == ST_SHIFT);
    assign busy       = (state_q == ST_SHIFT);
    assign frame_done = last_bit;

    // The output end of the register is fixed by MSB_FIRST; zeros fill from the other end.
    always_comb begin
        if (MSB_FIRST != 0) begin
            shifted = {shreg_q[WIDTH-2:0], 1'b0};
            out     = (state_q == ST_SHIFT) ? shreg_q[WIDTH-1] : 1'b0;
        end else begin
            shifted = {1'b0, shreg_q[WIDTH-1:1]};
            out     = (state_q == ST_SHIFT) ? shreg_q[0] : 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    shreg_d = data_in;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                if (last_bit) begin
                    cnt_d = '0;
                    if (accept) begin
                        shreg_d = data_in;
                    end else begin
                        shreg_d = shifted;
                        state_d = ST_IDLE;
                    end
                end else begin
                    shreg_d = shifted;
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: doc/piso_bit_serializer.md
Name: piso_bit_serializer

Overview:
Parallel-in/serial-out stage that feeds the sequence-detector FSMs (Mealy/Moore, overlapping/non-overlapping) one bit per clock. It accepts a WIDTH-bit word through a valid/ready load handshake and shifts it out on a single serial line. Its `out`/`out_valid` pair connects directly to the detector's `in` input, with an optional qualifier. Back-to-back words stream with no idle bubble, so overlapping patterns that span word boundaries remain detectable.

Parameters:
WIDTH, 8, bits per word; legal range WIDTH >= 2
MSB_FIRST, 1, 1 = bit WIDTH-1 is shifted out first; 0 = bit 0 is shifted out first

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  synchronous reset, active-high
data_in  input  WIDTH  word to serialize; sampled only on an accepted load
load_valid  input  1  upstream presents data_in
load_ready  output  1  block can accept a word this cycle
out  output  1  serial bit toward the detector `in`
out_valid  output  1  out carries a real data bit this cycle
busy  output  1  a frame is being shifted
frame_done  output  1  single-cycle pulse coincident with the last bit of a frame

Behaviour:
- One clock domain. Synchronous, active-high reset. No asynchronous paths.
- Internal state: FSM {IDLE, SHIFT}, WIDTH-bit shift register, bit counter of width $clog2(WIDTH).
- Reset:
  - While rst=1, load_valid is ignored.
  - After the reset edge: state=IDLE, shift register=0, counter=0.
  - After the reset edge, outputs are: out=0, out_valid=0, busy=0, frame_done=0, load_ready=1.
- Accept: a word is accepted on an edge where load_valid=1 and load_ready=1.
- load_ready: asserted (combinational from state/counter) when state=IDLE, or when state=SHIFT and counter=WIDTH-1 (last bit). Deasserted otherwise.
- IDLE:
  - out=0, out_valid=0, busy=0.
  - On accept: load shift register with data_in, counter=0, go to SHIFT.
- SHIFT:
  - out_valid=1, busy=1.
  - out = shift register MSB when MSB_FIRST=1, else LSB.
  - Each edge: shift by one toward the output end, counter increments.
- Latency: the first bit of a word appears on out in the cycle immediately after the accept edge. Exactly WIDTH consecutive out_valid cycles are produced per word.
- Last bit (counter=WIDTH-1):
  - frame_done=1 for that single cycle only.
  - Accept on that edge: reload from data_in, counter=0, stay in SHIFT. No gap between frames.
  - No accept on that edge: return to IDLE, counter=0.
- load_valid while load_ready=0: ignored. The word is not captured and the current frame is unaffected. Upstream must hold load_valid and data_in stable until the accept.
- Reset mid-frame: the frame is abandoned immediately. Remaining bits are never emitted and no frame_done is produced.
- The shifted-in fill bit is 0. It is never visible because out_valid gates use of out.

Test Plan:
1. MSB_FIRST=1, WIDTH=8, accept 8'b1011_0110 at cycle T -> out = 1,0,1,1,0,1,1,0 at T+1..T+8; out_valid=1 and busy=1 for those 8 cycles; frame_done=1 only at T+8; IDLE with out=0 at T+9.
2. MSB_FIRST=0, same word -> out = 0,1,1,0,1,1,0,1 at T+1..T+8; otherwise identical timing.
3. Back-to-back: accept 8'hA5, then hold load_valid=1 with 8'h3C -> second accept on the last-bit edge of 8'hA5; 16 contiguous out_valid cycles (1010_0101 then 0011_1100); two frame_done pulses, at cycles 8 and 16.
4. Load during frame: load_valid=1 with 8'hFF at bit 3 of an 8'h00 frame -> load_ready=0 and out stays 0 for all 8 bits; the 8'hFF word is accepted on the last-bit edge and streamed next.
5. Reset mid-frame: rst=1 for one cycle at bit 4 of 8'hF0 -> next cycle out=0, out_valid=0, busy=0, frame_done=0, load_ready=1; no further bits emitted; a new word is accepted normally.
6. System check: chain into the detector and feed words 8'b0000_0110, 8'b1000_0000 (overlap across boundary) -> the detector asserts its output at the boundary-spanning match. The serializer shows no out_valid gap across the boundary.
